// File: rtl/alu_operand_sequencer_if.sv
// ALU operand/result bus between the operand sequencer (master) and the ALU (slave).
interface alu_operand_sequencer_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] alu_a;
  logic [N_BITS-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [N_BITS-1:0] alu_res;
  logic              alu_ovf;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_res, alu_ovf
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_res, alu_ovf
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-driven operand/opcode sequencer for the ALU; captures and holds the result for display.
// Optional macro ALU_CHAIN_EN: enter in SHOW feeds the result back as operand A.
module alu_operand_sequencer #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] i_valor_in,
  input  logic              i_enter_btn,
  input  logic              i_undo_btn,
  alu_operand_sequencer_if.master alu_bus,
  output logic [N_BITS-1:0] o_resultado,
  output logic              o_overflow,
  output logic [N_BITS-1:0] o_display_val,
  output logic [2:0]        o_estado,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_enter_s1, r_enter_s2, r_enter_d;
  logic              r_undo_s1, r_undo_s2, r_undo_d;
  logic              w_enter_p, w_undo_p;
  logic              w_load_a, w_load_b, w_load_op, w_capture, w_err, w_chain;
  logic [N_BITS-1:0] r_alu_a, r_alu_b, r_resultado;
  logic [2:0]        r_alu_op;
  logic              r_overflow, r_done, r_err;

  function automatic logic op_valid(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
           (op == 3'b100) || (op == 3'b101);
  endfunction

  // Rising edge of the synchronized level; acts on the 3rd clk edge after the press
  assign w_enter_p = r_enter_s2 & ~r_enter_d;
  assign w_undo_p  = r_undo_s2  & ~r_undo_d;

  always_comb begin
    w_next_state = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_capture    = 1'b0;
    w_err        = 1'b0;
    w_chain      = 1'b0;
    case (r_state)
      GET_A: begin
        if (w_enter_p && !w_undo_p) begin
          w_load_a     = 1'b1;
          w_next_state = GET_B;
        end
      end
      GET_B: begin
        if (w_undo_p) begin
          w_next_state = GET_A;
        end else if (w_enter_p) begin
          w_load_b     = 1'b1;
          w_next_state = GET_OP;
        end
      end
      GET_OP: begin
        if (w_undo_p) begin
          w_next_state = GET_B;
        end else if (w_enter_p) begin
          if (op_valid(i_valor_in[2:0])) begin
            w_load_op    = 1'b1;
            w_next_state = EXEC;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      EXEC: begin
        w_capture    = 1'b1;
        w_next_state = SHOW;
      end
      SHOW: begin
        if (w_undo_p) begin
          w_next_state = GET_OP;
        end else if (w_enter_p) begin
`ifdef ALU_CHAIN_EN
          w_chain      = 1'b1;
          w_next_state = GET_B;
`else
          w_next_state = GET_A;
`endif
        end
      end
      default: w_next_state = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= GET_A;
      r_enter_s1  <= 1'b0;
      r_enter_s2  <= 1'b0;
      r_enter_d   <= 1'b0;
      r_undo_s1   <= 1'b0;
      r_undo_s2   <= 1'b0;
      r_undo_d    <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 3'b000;
      r_resultado <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_enter_s1  <= i_enter_btn;
      r_enter_s2  <= r_enter_s1;
      r_enter_d   <= r_enter_s2;
      r_undo_s1   <= i_undo_btn;
      r_undo_s2   <= r_undo_s1;
      r_undo_d    <= r_undo_s2;
      r_state     <= w_next_state;
      r_done      <= (w_next_state == SHOW);
      r_err       <= w_err;
      if (w_load_a)  r_alu_a <= i_valor_in;
      else if (w_chain) r_alu_a <= r_resultado;
      if (w_load_b)  r_alu_b  <= i_valor_in;
      if (w_load_op) r_alu_op <= i_valor_in[2:0];
      if (w_capture) begin
        r_resultado <= alu_bus.alu_res;
        r_overflow  <= alu_bus.alu_ovf;
      end
    end
  end

  always_comb begin
    o_display_val = i_valor_in;
    case (r_state)
      EXEC:    o_display_val = r_alu_b;
      SHOW:    o_display_val = r_resultado;
      default: o_display_val = i_valor_in;
    endcase
  end

  assign alu_bus.alu_a  = r_alu_a;
  assign alu_bus.alu_b  = r_alu_b;
  assign alu_bus.alu_op = r_alu_op;
  assign o_resultado    = r_resultado;
  assign o_overflow     = r_overflow;
  assign o_estado       = r_state;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small signed ALU model on the slave side.
module tb_alu_operand_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] valor_in = '0;
  logic         enter_btn = 1'b0;
  logic         undo_btn = 1'b0;
  logic [N-1:0] resultado, display_val;
  logic         overflow, done, err;
  logic [2:0]   estado;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_sequencer_if #(.N_BITS(N)) bus ();

  alu_operand_sequencer #(.N_BITS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valor_in    (valor_in),
    .i_enter_btn   (enter_btn),
    .i_undo_btn    (undo_btn),
    .alu_bus       (bus.master),
    .o_resultado   (resultado),
    .o_overflow    (overflow),
    .o_display_val (display_val),
    .o_estado      (estado),
    .o_done        (done),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  // Reference ALU: add, mul, and, sub, or with signed overflow
  logic signed [2*N-1:0] prod;
  logic        [N-1:0]   sum, dif;
  always_comb begin
    sum  = bus.alu_a + bus.alu_b;
    dif  = bus.alu_a - bus.alu_b;
    prod = $signed(bus.alu_a) * $signed(bus.alu_b);
    bus.alu_res = '0;
    bus.alu_ovf = 1'b0;
    case (bus.alu_op)
      3'b000: begin
        bus.alu_res = sum;
        bus.alu_ovf = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (sum[N-1] != bus.alu_a[N-1]);
      end
      3'b001: begin
        bus.alu_res = prod[N-1:0];
        bus.alu_ovf = (prod != {{N{prod[N-1]}}, prod[N-1:0]});
      end
      3'b010: bus.alu_res = bus.alu_a & bus.alu_b;
      3'b100: begin
        bus.alu_res = dif;
        bus.alu_ovf = (bus.alu_a[N-1] != bus.alu_b[N-1]) && (dif[N-1] != bus.alu_a[N-1]);
      end
      3'b101: bus.alu_res = bus.alu_a | bus.alu_b;
      default: bus.alu_res = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    enter_btn = 1'b0;
    undo_btn  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Idle long enough to clear the edge detectors, press, release at the negedge after the acting edge
  task automatic press(input logic en, input logic un, input logic [N-1:0] v);
    valor_in = v;
    repeat (3) @(negedge clk);
    enter_btn = en;
    undo_btn  = un;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enter_btn = 1'b0;
    undo_btn  = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] exp_res;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 3'b000, 8'h08, 1'b0};
    vecs[1] = '{8'h40, 8'h03, 3'b001, 8'hC0, 1'b1};
    vecs[2] = '{8'h03, 8'h05, 3'b100, 8'hFE, 1'b0};
    vecs[3] = '{8'h0F, 8'h3C, 3'b010, 8'h0C, 1'b0};
    vecs[4] = '{8'h50, 8'h0A, 3'b101, 8'h5A, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 3'b000, 8'h80, 1'b1};

    valor_in = 8'hA5;
    do_reset();
    check("rst_estado", estado, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_resultado", resultado, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_display_live", display_val, 8'hA5);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      press(1'b1, 1'b0, vecs[i].a);
      check("geta_to_getb", estado, 1);
      press(1'b1, 1'b0, vecs[i].b);
      check("getb_to_getop", estado, 2);
      press(1'b1, 1'b0, {5'b0, vecs[i].op});
      check("exec_state", estado, 3);
      check("exec_display_b", display_val, vecs[i].b);
      check("exec_alu_a", bus.alu_a, vecs[i].a);
      check("exec_alu_op", bus.alu_op, vecs[i].op);
      check("exec_done", done, 0);
      @(negedge clk);
      check("show_state", estado, 4);
      check("show_resultado", resultado, vecs[i].exp_res);
      check("show_overflow", overflow, vecs[i].exp_ovf);
      check("show_done", done, 1);
      check("show_display", display_val, vecs[i].exp_res);
    end

    // Leaving SHOW with enter (last vector: 0x7F + 0x01 = 0x80)
    press(1'b1, 1'b0, 8'h11);
`ifdef ALU_CHAIN_EN
    check("show_enter_state", estado, 1);
    check("show_enter_alu_a", bus.alu_a, 8'h80);
`else
    check("show_enter_state", estado, 0);
    check("show_enter_alu_a", bus.alu_a, 8'h7F);
`endif
    check("show_enter_done", done, 0);

    // Undo from SHOW returns to GET_OP
    do_reset();
    press(1'b1, 1'b0, 8'h01);
    press(1'b1, 1'b0, 8'h02);
    press(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("show_pre_undo", estado, 4);
    press(1'b0, 1'b1, 8'h00);
    check("show_undo_state", estado, 2);
    check("show_undo_done", done, 0);
    check("show_undo_keep_res", resultado, 8'h03);

    // Invalid opcode, undo, simultaneous buttons
    do_reset();
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h03);
    check("badop_state", estado, 2);
    check("badop_err", err, 1);
    check("badop_alu_op", bus.alu_op, 0);
    @(negedge clk);
    check("badop_err_clear", err, 0);
    check("badop_state_hold", estado, 2);
    press(1'b0, 1'b1, 8'h00);
    check("getop_undo_state", estado, 1);
    press(1'b1, 1'b1, 8'h22);
    check("both_btn_state", estado, 0);
    check("both_btn_alu_b", bus.alu_b, 8'h03);
    check("both_btn_alu_a", bus.alu_a, 8'h05);
    press(1'b0, 1'b1, 8'h00);
    check("geta_undo_state", estado, 0);

    // Held enter produces a single transition
    do_reset();
    valor_in = 8'h33;
    @(negedge clk);
    enter_btn = 1'b1;
    repeat (20) @(negedge clk);
    enter_btn = 1'b0;
    check("held_state", estado, 1);
    check("held_alu_a", bus.alu_a, 8'h33);
    repeat (6) @(negedge clk);
    check("held_state_after", estado, 1);

    // Async reset mid-EXEC
    do_reset();
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h00);
    check("pre_async_exec", estado, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_estado", estado, 0);
    check("async_alu_a", bus.alu_a, 0);
    check("async_alu_b", bus.alu_b, 0);
    check("async_alu_op", bus.alu_op, 0);
    check("async_resultado", resultado, 0);
    check("async_overflow", overflow, 0);
    check("async_done", done, 0);
    check("async_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ALU_CHAIN_EN
    do_reset();
    press(1'b1, 1'b0, 8'h02);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("chain_first_res", resultado, 8'h05);
    press(1'b1, 1'b0, 8'h00);
    check("chain_state", estado, 1);
    check("chain_alu_a", bus.alu_a, 8'h05);
    press(1'b1, 1'b0, 8'h01);
    press(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("chain_second_res", resultado, 8'h06);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end controller that drives the generalized ALU: collects operand A, operand B and an opcode from board switches, one button press per item.
- Drives the ALU operand/opcode inputs from registers, captures the combinational result and overflow flag one cycle later, and holds them for display.
- Sits between the debounced board buttons/switches and the ALU / VGA display path.

Parameters:
- N_BITS, 8, operand/result width; must equal the ALU data width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- valor_in  input  N_BITS  switch value (operand or opcode in bits [2:0])
- enter_btn  input  1  debounced button level; asynchronous to clk
- undo_btn  input  1  debounced button level; asynchronous to clk
- alu_a  output  N_BITS  registered operand A to ALU
- alu_b  output  N_BITS  registered operand B to ALU
- alu_op  output  3  registered opcode to ALU
- alu_res  input  N_BITS  ALU result (combinational)
- alu_ovf  input  1  ALU overflow flag
- resultado  output  N_BITS  captured result
- overflow  output  1  captured overflow
- display_val  output  N_BITS  value to show
- estado  output  3  current state encoding
- done  output  1  high while in SHOW
- err  output  1  one-cycle pulse on rejected opcode

Behaviour:
- Reset (async, rst_n=0): state=GET_A; alu_a, alu_b, alu_op, resultado = 0; overflow, done, err = 0; synchronizer and edge registers = 0. Applies immediately, including mid-operation.
- Button conditioning: each button goes through a 2-FF synchronizer and a rising-edge detector.
  - The pulse acts on the 3rd rising clk edge after the level first rises.
  - Holding the button produces exactly one pulse.
- States: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4.
- GET_A:
  - enter: alu_a <= valor_in, go to GET_B.
  - undo: no effect.
- GET_B:
  - enter: alu_b <= valor_in, go to GET_OP.
  - undo: go to GET_A; alu_a retained.
- GET_OP:
  - enter with valor_in[2:0] in {000,001,010,100,101}: alu_op <= valor_in[2:0], go to EXEC.
  - enter with any other code: stay in GET_OP, err=1 for exactly one cycle, alu_op unchanged.
  - undo: go to GET_B.
- EXEC: exactly one cycle, buttons ignored. resultado <= alu_res, overflow <= alu_ovf, then go to SHOW.
- SHOW:
  - done=1.
  - enter: go to GET_A; all registers keep their values until overwritten.
  - undo: go to GET_OP.
- Simultaneous enter and undo pulses in the same cycle: undo wins, enter is discarded.
- display_val:
  - valor_in (live) in GET_A, GET_B and GET_OP.
  - alu_b in EXEC.
  - resultado in SHOW.
- estado reflects the registered state; all outputs except display_val are registered.
- Arithmetic is done by the ALU; result width is N_BITS, with truncation inherited from the ALU.

Optional Feature:
- Macro ALU_CHAIN_EN.
- Defined: enter in SHOW sets alu_a <= resultado and goes directly to GET_B, so successive operations chain on the previous result.
- Undefined: enter in SHOW goes to GET_A as described above; resultado is never fed back.

Test Plan:
- Add: reset, then enter 0x05, 0x03, op 000 → EXEC one cycle, SHOW with resultado=0x08, overflow=0, done=1, display_val=0x08.
- Multiply with overflow: A=0x40, B=0x03, op 001 → resultado=0xC0, overflow=1.
- Subtract: A=0x03, B=0x05, op 100 → resultado=0xFE, overflow=0.
- Invalid opcode and undo: in GET_OP enter op 011 → err high one cycle, state stays 2. Then undo → state 1. Then pressing undo and enter in the same cycle → state 0.
- Held button and async reset: hold enter 20 cycles in GET_A → single transition to GET_B. Assert rst_n=0 mid-EXEC → immediate GET_A, all outputs 0.
- ALU_CHAIN_EN defined: 0x02+0x03=0x05, then enter in SHOW → alu_a=0x05, state GET_B. Then B=0x01, op 000 → resultado=0x06.
